// File: rtl/topview_seg_sched.sv
// Readout scheduler: streams the top-view segment table to one valid/ready consumer.
// Optional build macro TOPVIEW_SEG_SKIP_INVALID_EN drops table words whose ok bit is 0.
module topview_seg_sched #(
  parameter int RAM_ADDR_W = 12,
  parameter int OUT_V_BITW = 9,
  parameter int OUT_H_BITW = 10,
  localparam int DATA_WIDTH = 2*(OUT_V_BITW+OUT_H_BITW)+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tv_ready,
  input  logic [RAM_ADDR_W-1:0] tv_line_num,
  output logic [RAM_ADDR_W-1:0] tv_raddr,
  input  logic [DATA_WIDTH-1:0] tv_rdata,
  output logic                  seg_valid,
  input  logic                  seg_ready,
  output logic [OUT_V_BITW-1:0] seg_start_v,
  output logic [OUT_H_BITW-1:0] seg_start_h,
  output logic [OUT_V_BITW-1:0] seg_end_v,
  output logic [OUT_H_BITW-1:0] seg_end_h,
  output logic                  seg_ok,
  output logic                  seg_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [RAM_ADDR_W-1:0] seg_count
);

  // FIFO entry = {table word, last flag}; offsets below index into that entry
  localparam int EH_LO = 2;
  localparam int EV_LO = EH_LO + OUT_H_BITW;
  localparam int SH_LO = EV_LO + OUT_V_BITW;
  localparam int SV_LO = SH_LO + OUT_H_BITW;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic                  r_ready_d;
  logic [RAM_ADDR_W-1:0] r_n;
  logic [RAM_ADDR_W-1:0] r_rd_addr;
  logic [RAM_ADDR_W-1:0] r_raddr;
  logic [RAM_ADDR_W-1:0] r_seg_count;
  logic                  r_pend;
  logic                  r_pend_last;
  logic [DATA_WIDTH:0]   r_mem [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic                  r_frame_done;
  logic                  r_frame_abort;

  logic [DATA_WIDTH:0]   w_head;
  logic                  w_pop;
  logic                  w_push;
  logic [1:0]            w_cnt_next;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_rise;
  logic                  w_abort;
  logic [RAM_ADDR_W-1:0] w_rd_inc;

  assign w_head = r_mem[r_rp];
  assign w_pop  = (r_cnt != 2'd0) && seg_ready;
`ifdef TOPVIEW_SEG_SKIP_INVALID_EN
  assign w_push = r_pend && tv_rdata[0];
`else
  assign w_push = r_pend;
`endif
  assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // Counting an in-flight read as occupied keeps the 2-entry FIFO from overflowing
  assign w_occ    = {1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
  assign w_issue  = (r_state == S_READ) && (r_rd_addr < r_n) && (w_occ < 3'd2);
  assign w_rise   = tv_ready && !r_ready_d;
  assign w_abort  = ((r_state == S_READ) || (r_state == S_DRAIN)) && !tv_ready;
  assign w_rd_inc = r_rd_addr + RAM_ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ready_d     <= 1'b1;  // a level-high tv_ready at release must not start a frame
      r_n           <= '0;
      r_rd_addr     <= '0;
      r_raddr       <= '0;
      r_seg_count   <= '0;
      r_pend        <= 1'b0;
      r_pend_last   <= 1'b0;
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_cnt         <= 2'd0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_ready_d     <= tv_ready;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_n         <= tv_line_num;
            r_rd_addr   <= '0;
            r_raddr     <= '0;
            r_seg_count <= '0;
            r_pend      <= 1'b0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_cnt       <= 2'd0;
            if (tv_line_num == '0) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ, S_DRAIN: begin
          if (w_abort) begin
            r_state       <= S_IDLE;
            r_pend        <= 1'b0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_cnt         <= 2'd0;
            r_frame_abort <= 1'b1;
          end else begin
            r_pend <= w_issue;
            if (w_issue) begin
              r_pend_last <= (r_rd_addr == r_n - RAM_ADDR_W'(1));
              r_rd_addr   <= w_rd_inc;
              if (w_rd_inc < r_n)
                r_raddr <= w_rd_inc;
            end
            if (w_push) begin
              r_mem[r_wp] <= {tv_rdata, r_pend_last};
              r_wp        <= ~r_wp;
            end
            if (w_pop) begin
              r_rp <= ~r_rp;
              if (~&r_seg_count)
                r_seg_count <= r_seg_count + RAM_ADDR_W'(1);
            end
            r_cnt <= w_cnt_next;
            // Going straight to DONE when the final pop empties the FIFO saves a cycle
            if (r_state == S_READ) begin
              if ((r_rd_addr == r_n) && !r_pend) begin
                if (w_cnt_next == 2'd0) begin
                  r_state      <= S_DONE;
                  r_frame_done <= 1'b1;
                end else begin
                  r_state <= S_DRAIN;
                end
              end
            end else if (w_cnt_next == 2'd0) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tv_raddr    = r_raddr;
  assign seg_valid   = (r_cnt != 2'd0);
  assign seg_last    = w_head[0];
  assign seg_ok      = w_head[1];
  assign seg_end_h   = w_head[EV_LO-1:EH_LO];
  assign seg_end_v   = w_head[SH_LO-1:EV_LO];
  assign seg_start_h = w_head[SV_LO-1:SH_LO];
  assign seg_start_v = w_head[DATA_WIDTH:SV_LO];
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign seg_count   = r_seg_count;

endmodule
